// File: rtl/risc_pkg.sv
// Shared definitions for the memory-stage data path.
// Holds the datapath and address widths, the data-memory responder state
// encoding and a helper that flags word addresses outside the storage.
package risc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  // Responder states. StWait is only reachable when DMEM_WAIT_EN is defined.
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } rsp_state_e;

  // An address is out of range when any bit at or above depth_log2 is set.
  function automatic logic addr_oor(input logic [ADDR_W-1:0] addr,
                                    input int unsigned       depth_log2);
    return (addr >> depth_log2) != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: 2**DEPTH_LOG2 words of DATA_W bits.
// Synchronous write and a registered read port. The stored words and the
// read register are not reset.
//
// Ports:
//   clk    clock
//   we     write enable, writes wdata at addr on the rising edge
//   re     read enable, registers mem[addr] into rdata on the rising edge
//   addr   word address
//   wdata  write data
//   rdata  registered read data, held until the next read
module dmem_array
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory stage of the pipeline.
// Accepts one load or store at a time, answers with a one-cycle rsp_valid
// pulse and asks the pipeline to hold (stall) while it is busy.
//
// Optional feature: define DMEM_WAIT_EN to give loads WAIT_CYCLES wait states
// (WAIT_CYCLES = 0 then behaves like the plain build).
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_we     1 = store, 0 = load
//   req_addr   word address
//   req_wdata  store data
//   req_ready  request can be accepted this cycle (idle)
//   rsp_valid  one-cycle completion pulse
//   rsp_rdata  load data, zero unless rsp_valid
//   rsp_err    out-of-range flag, zero unless rsp_valid
//   stall      req_valid & ~req_ready
module dmem_responder
  import risc_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  rsp_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              accept;
  logic              in_oor;
  logic [DATA_W-1:0] arr_rdata;

`ifdef DMEM_WAIT_EN
  localparam bit          WaitEn = WAIT_CYCLES != 0;
  // Counter holds at most WAIT_CYCLES-1.
  localparam int unsigned CntW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign stall     = req_valid & ~req_ready;
  assign in_oor    = addr_oor(req_addr, DEPTH_LOG2);

  // Stores land in the array at the accept edge; loads are read at the accept
  // edge and the registered data is held until the response.
  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (accept & req_we & ~in_oor),
    .re   (accept & ~req_we & ~in_oor),
    .addr (req_addr[DEPTH_LOG2-1:0]),
    .wdata(req_wdata),
    .rdata(arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
`ifdef DMEM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d  = req_we;
          err_d = in_oor;
`ifdef DMEM_WAIT_EN
          if (!req_we && WaitEn) begin
            state_d = StWait;
            cnt_d   = CntW'(WAIT_CYCLES - 1);
          end else begin
            state_d = StResp;
          end
`else
          state_d = StResp;
`endif
        end
      end
      StWait: begin
`ifdef DMEM_WAIT_EN
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef DMEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Response fields are forced to zero outside the response cycle; stores and
  // out-of-range loads return zero data.
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid & ~we_q & ~err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random
// loads/stores checked against a flat word-array model with fixed latencies.
module tb_dmem_responder;

  localparam int unsigned DEPTH_LOG2  = 8;
  localparam int unsigned WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_EN
  localparam int LoadLat = 1 + WAIT_CYCLES;
`else
  localparam int LoadLat = 1;
`endif
  localparam logic [15:0] HoldAddr = 16'h00F0;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  int n_total = 0;
  int n_bad   = 0;
  int pulses  = 0;

  logic [15:0] model [256];

  dmem_responder #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rsp_valid === 1'b1) pulses++;

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Starts and ends at a negedge in the idle state; the next call may issue
  // immediately, giving the minimum 2-cycle spacing after a store.
  task automatic xact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                      input bit hold);
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          lat;
    exp_err = (addr > 16'd255);
    lat     = we ? 1 : LoadLat;
    if (we || exp_err) exp_rdata = 16'h0;
    else               exp_rdata = model[addr[7:0]];
    if (we && !exp_err) model[addr[7:0]] = wdata;

    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    if (hold) begin
      // A second request held while busy; it must be ignored, not queued.
      req_we    = 1'b1;
      req_addr  = HoldAddr;
      req_wdata = 16'hDEAD;
    end else begin
      req_valid = 1'b0;
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, c == lat});
      chk("ready_busy", {31'b0, req_ready}, 32'd0);
      chk("stall", {31'b0, stall}, {31'b0, hold});
      if (c == lat) begin
        chk("rsp_rdata", {16'b0, rsp_rdata}, {16'b0, exp_rdata});
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
      end else begin
        chk("rdata_quiet", {16'b0, rsp_rdata}, 32'd0);
        chk("err_quiet", {31'b0, rsp_err}, 32'd0);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("valid_after", {31'b0, rsp_valid}, 32'd0);
    chk("rdata_after", {16'b0, rsp_rdata}, 32'd0);
    chk("err_after", {31'b0, rsp_err}, 32'd0);
  endtask

  // Reset asserted right after acceptance: no response may ever appear.
  task automatic reset_mid(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int p0;
    if (we && addr <= 16'd255) model[addr[7:0]] = wdata;
    p0        = pulses;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", {16'b0, rsp_rdata}, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    end
    chk("rst_no_pulse", pulses, p0);
  endtask

  initial begin
    logic [15:0] a;
    logic        w;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rdata", {16'b0, rsp_rdata}, 32'd0);
    chk("reset_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios.
    xact(1'b1, 16'h0005, 16'hBEEF, 1'b0);
    xact(1'b0, 16'h0005, 16'h0, 1'b0);
    xact(1'b0, 16'h0005, 16'h0, 1'b1);
    xact(1'b1, 16'h0100, 16'h1234, 1'b0);
    xact(1'b0, 16'h0000, 16'h0, 1'b0);
    xact(1'b0, HoldAddr, 16'h0, 1'b0);
    xact(1'b0, 16'h8005, 16'h0, 1'b0);
    reset_mid(1'b0, 16'h0005, 16'h0);
    reset_mid(1'b1, 16'h0020, 16'h5A5A);
    xact(1'b0, 16'h0020, 16'h0, 1'b0);
    xact(1'b1, 16'h0033, 16'h00AA, 1'b0);
    xact(1'b0, 16'h0033, 16'h0, 1'b0);

    // Fill every word so random loads have known contents.
    for (int i = 0; i < 256; i++) begin
      xact(1'b1, 16'(i), 16'($urandom), 1'b0);
    end

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(7) == 0) a = 16'($urandom_range(16'hFFFF, 16'h0100));
      else                        a = 16'($urandom_range(255));
      w = 1'($urandom_range(1));
      xact(w, a, 16'($urandom), bit'($urandom_range(3) == 0));
    end
    xact(1'b0, HoldAddr, 16'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
